regfile_wr_arbiter: RTL

Write-port arbiter and sequencer for the 32-entry MIPS register file. It shares the file's single write port among up to N_REQ writeback sources: ALU result, memory load data and the debug/init loader. It picks one requester per cycle by round-robin and registers the winning address and data. It then drives the register file's write strobe and one-hot enable vector, which connect to the file's `reg_write_i` and `CP_o` inputs. Writes to `$zero` are granted but suppressed.

---
 rtl/regfile_wr_arbiter_if.sv | 31 +++
 rtl/regfile_wr_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wr_arbiter_if                                                |
// | Requester-side and register-file-side signals of the write arbiter.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_wr_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]       req_i;
    logic [5*N_REQ-1:0]     addr_i;
    logic [WIDTH*N_REQ-1:0] data_i;
    logic [N_REQ-1:0]       gnt_o;
    logic                   reg_write_o;
    logic [31:0]            wr_en_o;
    logic [4:0]             wr_addr_o;
    logic [WIDTH-1:0]       wr_data_o;
    logic                   busy_o;

    modport master (
        output req_i, addr_i, data_i,
        input  gnt_o, reg_write_o, wr_en_o, wr_addr_o, wr_data_o, busy_o
    );

    modport slave (
        input  req_i, addr_i, data_i,
        output gnt_o, reg_write_o, wr_en_o, wr_addr_o, wr_data_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_wr_arbiter                                                   |
// | Round-robin sharing of the register file's single write port.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_wr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 3
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wr_arbiter_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               reg_write_q, reg_write_d;
    logic [31:0]        wr_en_q, wr_en_d;
    logic [4:0]         wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;

    logic [N_REQ-1:0]   shown_gnt;
    logic [N_REQ-1:0]   elig;
    logic               found;
    logic               found_hi;
    logic [PTR_W-1:0]   win, win_hi, win_lo;
    logic [4:0]         win_addr;
    logic [WIDTH-1:0]   win_data;

    // The requester shown as granted is masked so it can drop its request.
    assign shown_gnt = (state_q == WRITE) ? gnt_q : '0;
    assign elig      = bus.req_i & ~shown_gnt;

    // Lowest eligible index at or above ptr wins; otherwise wrap to lowest overall.
    always_comb begin
        found_hi = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (elig[j]) begin
                win_lo = j[PTR_W-1:0];
                if (j >= int'(ptr_q)) begin
                    found_hi = 1'b1;
                    win_hi   = j[PTR_W-1:0];
                end
            end
        end
        win   = found_hi ? win_hi : win_lo;
        found = |elig;

        win_addr = '0;
        win_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (win == j[PTR_W-1:0]) begin
                win_addr = bus.addr_i[5*j +: 5];
                win_data = bus.data_i[WIDTH*j +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = IDLE;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        reg_write_d = 1'b0;
        wr_en_d     = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        if (found) begin
            state_d     = WRITE;
            ptr_d       = (win == LAST_IDX) ? '0 : win + PTR_W'(1);
            gnt_d       = N_REQ'(1) << win;
            wr_addr_d   = win_addr;
            wr_data_d   = win_data;
            // $zero is granted to release the requester but never written.
            reg_write_d = (win_addr != 5'd0);
            wr_en_d     = reg_write_d ? (32'd1 << win_addr) : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            reg_write_q <= 1'b0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            reg_write_q <= reg_write_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.reg_write_o = reg_write_q;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.busy_o      = |elig;

endmodule
`default_nettype wire
